// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point divider (and multiplier).
// Optional feature macro used by the divider: FPD_FLAGS_EN (exception flags port).
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] INF_EXP = 8'hFF;

  // Restoring division produces one quotient bit per DIV cycle.
  localparam logic [4:0] DIV_LAST = 5'd25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_DIV    = 3'd2,
    ST_ROUND  = 3'd3,
    ST_DONE   = 3'd4
  } fpd_state_e;

  // Bit positions inside the 5-bit flags vector.
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  function automatic logic [31:0] signed_inf(input logic s);
    return {s, INF_EXP, 23'd0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'd0};
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational binary32 field splitter. Exponent 0 is reported as zero so
// denormal operands are flushed by the consumer.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]      op,
  output logic             sign,
  output logic [EXP_W-1:0] expo,
  output logic [MAN_W:0]   man,
  output logic             is_zero,
  output logic             is_inf,
  output logic             is_nan
);

  // Field extraction and operand classification.
  always_comb begin
    sign    = op[31];
    expo    = op[30:23];
    man     = {1'b1, op[22:0]};
    is_zero = (op[30:23] == 8'd0);
    is_inf  = (op[30:23] == INF_EXP) && (op[22:0] == 23'd0);
    is_nan  = (op[30:23] == INF_EXP) && (op[22:0] != 23'd0);
  end

endmodule

// File: rtl/fpd_32.sv
// Iterative binary32 divider: restoring radix-2 mantissa division (26 cycles),
// round-to-nearest-even, flush-to-zero on input and output.
// Define FPD_FLAGS_EN to add the {invalid, divzero, overflow, underflow, inexact} port.
module fpd_32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] q,
  output logic        busy,
  output logic        done
`ifdef FPD_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  fpd_state_e         state_r;
  logic [31:0]        x_r, y_r, q_r;
  logic               busy_r, done_r, sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        mb_r;
  logic [24:0]        rem_r;
  logic [25:0]        quo_r;
  logic [4:0]         cnt_r;

  logic               xa_sign_s, yb_sign_s;
  logic [EXP_W-1:0]   xa_exp_s, yb_exp_s;
  logic [MAN_W:0]     xa_man_s, yb_man_s;
  logic               xa_zero_s, xa_inf_s, xa_nan_s;
  logic               yb_zero_s, yb_inf_s, yb_nan_s;

  logic               res_sign_s, spec_hit_s;
  logic [31:0]        spec_q_s;
  logic               ge_s;
  logic [24:0]        sub_s;

  logic [23:0]        rnd_man_s;
  logic               rnd_guard_s, rnd_sticky_s, rnd_inc_s;
  logic [24:0]        rnd_sum_s;
  logic [22:0]        rnd_frac_s;
  logic signed [9:0]  rnd_e1_s, rnd_e2_s;
  logic [31:0]        rnd_q_s;

`ifdef FPD_FLAGS_EN
  logic [4:0]         flags_r, spec_flags_s, rnd_flags_s;
`endif

  fp32_unpack u_unpack_x (
    .op(x_r), .sign(xa_sign_s), .expo(xa_exp_s), .man(xa_man_s),
    .is_zero(xa_zero_s), .is_inf(xa_inf_s), .is_nan(xa_nan_s)
  );

  fp32_unpack u_unpack_y (
    .op(y_r), .sign(yb_sign_s), .expo(yb_exp_s), .man(yb_man_s),
    .is_zero(yb_zero_s), .is_inf(yb_inf_s), .is_nan(yb_nan_s)
  );

  // Special-operand resolution in priority order: NaN, invalid, infinity, zero.
  always_comb begin
    res_sign_s = xa_sign_s ^ yb_sign_s;
    spec_hit_s = 1'b1;
    spec_q_s   = 32'd0;
`ifdef FPD_FLAGS_EN
    spec_flags_s = 5'd0;
`endif
    if (xa_nan_s || yb_nan_s) begin
      spec_q_s = QNAN;
    end else if ((xa_zero_s && yb_zero_s) || (xa_inf_s && yb_inf_s)) begin
      spec_q_s = QNAN;
`ifdef FPD_FLAGS_EN
      spec_flags_s[FLG_INVALID] = 1'b1;
`endif
    end else if (xa_inf_s || yb_zero_s) begin
      spec_q_s = signed_inf(res_sign_s);
`ifdef FPD_FLAGS_EN
      spec_flags_s[FLG_DIVZERO] = yb_zero_s & ~xa_inf_s;
`endif
    end else if (xa_zero_s || yb_inf_s) begin
      spec_q_s = signed_zero(res_sign_s);
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  // One restoring step: trial-subtract the divisor from the partial remainder.
  always_comb begin
    ge_s  = (rem_r >= {1'b0, mb_r});
    sub_s = rem_r - {1'b0, mb_r};
  end

  // Normalise the 26-bit quotient, round to nearest even, then range-check.
  always_comb begin
    rnd_sticky_s = (rem_r != 25'd0);
    if (quo_r[25]) begin
      rnd_man_s    = quo_r[25:2];
      rnd_guard_s  = quo_r[1];
      rnd_sticky_s = rnd_sticky_s | quo_r[0];
      rnd_e1_s     = exp_r;
    end else begin
      rnd_man_s    = quo_r[24:1];
      rnd_guard_s  = quo_r[0];
      rnd_e1_s     = exp_r - 10'sd1;
    end
    rnd_inc_s  = rnd_guard_s & (rnd_sticky_s | rnd_man_s[0]);
    rnd_sum_s  = {1'b0, rnd_man_s} + {24'd0, rnd_inc_s};
    rnd_frac_s = rnd_sum_s[24] ? rnd_sum_s[23:1] : rnd_sum_s[22:0];
    rnd_e2_s   = rnd_e1_s + $signed({9'd0, rnd_sum_s[24]});
`ifdef FPD_FLAGS_EN
    rnd_flags_s = 5'd0;
`endif
    if (rnd_e2_s >= 10'sd255) begin
      rnd_q_s = signed_inf(sign_r);
`ifdef FPD_FLAGS_EN
      rnd_flags_s[FLG_OVERFLOW] = 1'b1;
      rnd_flags_s[FLG_INEXACT]  = 1'b1;
`endif
    end else if (rnd_e2_s <= 10'sd0) begin
      rnd_q_s = signed_zero(sign_r);
`ifdef FPD_FLAGS_EN
      rnd_flags_s[FLG_UNDERFLOW] = 1'b1;
      rnd_flags_s[FLG_INEXACT]   = 1'b1;
`endif
    end else begin
      rnd_q_s = {sign_r, rnd_e2_s[7:0], rnd_frac_s};
`ifdef FPD_FLAGS_EN
      rnd_flags_s[FLG_INEXACT] = rnd_guard_s | rnd_sticky_s;
`endif
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      x_r     <= 32'd0;
      y_r     <= 32'd0;
      q_r     <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sign_r  <= 1'b0;
      exp_r   <= 10'sd0;
      mb_r    <= 24'd0;
      rem_r   <= 25'd0;
      quo_r   <= 26'd0;
      cnt_r   <= 5'd0;
`ifdef FPD_FLAGS_EN
      flags_r <= 5'd0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            busy_r  <= 1'b1;
            state_r <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          if (spec_hit_s) begin
            q_r     <= spec_q_s;
`ifdef FPD_FLAGS_EN
            flags_r <= spec_flags_s;
`endif
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            sign_r  <= res_sign_s;
            exp_r   <= $signed({2'b00, xa_exp_s}) - $signed({2'b00, yb_exp_s}) + 10'sd127;
            mb_r    <= yb_man_s;
            rem_r   <= {1'b0, xa_man_s};
            quo_r   <= 26'd0;
            cnt_r   <= 5'd0;
            state_r <= ST_DIV;
          end
        end
        ST_DIV: begin
          rem_r <= (ge_s ? sub_s : rem_r) << 1'b1;
          quo_r <= {quo_r[24:0], ge_s};
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == DIV_LAST) begin
            state_r <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          q_r     <= rnd_q_s;
`ifdef FPD_FLAGS_EN
          flags_r <= rnd_flags_s;
`endif
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = q_r;
  assign busy = busy_r;
  assign done = done_r;
`ifdef FPD_FLAGS_EN
  assign flags = flags_r;
`endif

endmodule

// File: tb/tb_fpd_32.sv
// Self-checking bench for fpd_32: directed plan vectors, mid-operation start
// and reset, then random operands against an exact rational reference model.
module tb_fpd_32;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x, y, q;
  logic        busy, done;
`ifdef FPD_FLAGS_EN
  logic [4:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  fpd_32 dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .q(q), .busy(busy), .done(done)
`ifdef FPD_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {special, flags[4:0], q[31:0]} from exact quotient arithmetic.
  function automatic logic [37:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic   s, an, bn, ai, bi, az, bz;
    longint ea, eb, ma, mb, num, qi, r, e;
    logic   inx;
    s  = a[31] ^ b[31];
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    if (an || bn) return {1'b1, 5'b00000, 32'h7FC0_0000};
    if ((az && bz) || (ai && bi)) return {1'b1, 5'b10000, 32'h7FC0_0000};
    if (ai || bz) return {1'b1, (bz && !ai) ? 5'b01000 : 5'b00000, s, 8'hFF, 23'd0};
    if (az || bi) return {1'b1, 5'b00000, s, 31'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    if (ma >= mb) begin
      num = ma << 23;
      e   = ea - eb + 127;
    end else begin
      num = ma << 24;
      e   = ea - eb + 126;
    end
    qi  = num / mb;
    r   = num % mb;
    inx = (r != 0);
    if ((2 * r > mb) || ((2 * r == mb) && qi[0])) qi = qi + 1;
    if (qi == (longint'(1) << 24)) begin
      qi = qi >> 1;
      e  = e + 1;
    end
    if (e >= 255) return {1'b0, 5'b00101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, 5'b00011, s, 31'd0};
    return {1'b0, 4'b0000, inx, s, e[7:0], qi[22:0]};
  endfunction

  // Run one division; optionally pulse start again in cycle 'poke'.
  task automatic run_div(input logic [31:0] xv, input logic [31:0] yv, input int poke,
                         output logic [31:0] got_q);
    logic [37:0] exp_v;
    int cyc, busy_cnt, done_cyc, exp_cyc, extra;
    logic got_done;
    exp_v   = ref_div(xv, yv);
    exp_cyc = exp_v[37] ? 2 : 29;
    x = xv; y = yv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; busy_cnt = 0; done_cyc = 0; got_done = 1'b0;
    while (cyc <= 40 && !got_done) begin
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
      end else begin
        if (busy) busy_cnt++;
        x = $urandom; y = $urandom;
        start = (cyc == poke);
        tick();
        start = 1'b0;
        cyc++;
      end
    end
    got_q = q;
    check_eq("done_cycle", 32'(done_cyc), 32'(exp_cyc));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_cyc - 1));
    check_eq("busy_at_done", {31'd0, busy}, 32'd0);
    check_eq("q", q, exp_v[31:0]);
`ifdef FPD_FLAGS_EN
    check_eq("flags", {27'd0, flags}, {27'd0, exp_v[36:32]});
`endif
    tick();
    check_eq("done_pulse", {31'd0, done}, 32'd0);
    check_eq("q_hold", q, exp_v[31:0]);
    if (poke != 0) begin
      extra = 0;
      repeat (40) begin
        if (done) extra++;
        tick();
      end
      check_eq("ignored_start", 32'(extra), 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    logic [22:0] f;
    int kind;
    kind = $urandom_range(0, 11);
    f = 23'($urandom);
    case (kind)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; f = f | 23'd1; end
      3:       e = 8'($urandom_range(250, 254));
      4:       e = 8'($urandom_range(1, 4));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] rq;
  int extra_dn;

  initial begin
    rst = 1'b1; start = 1'b0; x = 32'd0; y = 32'd0;
    repeat (3) tick();
    check_eq("rst_q", q, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
`ifdef FPD_FLAGS_EN
    check_eq("rst_flags", {27'd0, flags}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    run_div(32'h40C0_0000, 32'h4000_0000, 0, rq); check_eq("plan_6div2", rq, 32'h4040_0000);
    run_div(32'h3F80_0000, 32'h4040_0000, 0, rq); check_eq("plan_1div3", rq, 32'h3EAA_AAAB);
    run_div(32'hBF80_0000, 32'h4000_0000, 0, rq); check_eq("plan_neg", rq, 32'hBF00_0000);
    run_div(32'h3F80_0000, 32'h0000_0000, 0, rq); check_eq("plan_divzero", rq, 32'h7F80_0000);
    run_div(32'h0000_0000, 32'h0000_0000, 0, rq); check_eq("plan_0div0", rq, 32'h7FC0_0000);
    run_div(32'h7F7F_FFFF, 32'h3F00_0000, 0, rq); check_eq("plan_ovf", rq, 32'h7F80_0000);
    run_div(32'h0080_0000, 32'h4000_0000, 0, rq); check_eq("plan_unf", rq, 32'h0000_0000);
    run_div(32'h7F80_0000, 32'h7F80_0000, 0, rq); check_eq("plan_infinf", rq, 32'h7FC0_0000);

    // Start re-asserted in cycle 5 must not disturb or queue.
    run_div(32'h40C0_0000, 32'h4000_0000, 5, rq); check_eq("poke_6div2", rq, 32'h4040_0000);

    // Reset in cycle 10 aborts the division without a later done pulse.
    x = 32'h3F80_0000; y = 32'h4040_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    check_eq("abort_q", q, 32'd0);
`ifdef FPD_FLAGS_EN
    check_eq("abort_flags", {27'd0, flags}, 32'd0);
`endif
    extra_dn = 0;
    repeat (40) begin
      if (done) extra_dn++;
      tick();
    end
    check_eq("abort_no_done", 32'(extra_dn), 32'd0);
    run_div(32'h40C0_0000, 32'h4000_0000, 0, rq); check_eq("after_rst", rq, 32'h4040_0000);

    for (int i = 0; i < 60; i++) begin
      run_div(rnd_op(), rnd_op(), 0, rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
